// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide sequencer beside EX.
// Shift-add multiply / restoring divide over 32 steps; results in HI/LO.
// Ports: clk, rst_n (sync, active-low), start/op/op_a/op_b (request),
//   rd_req (HI/LO read), flush (squash), busy, stall, done, hi, lo.
// Option: define MULDIV_SIGNED_EN to honour op[1] (signed) via a FIX state.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        rd_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
`ifdef MULDIV_SIGNED_EN
        ,
        FIX     = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

`ifdef MULDIV_SIGNED_EN
    logic sgn_q, sgn_d;
    logic neg_q, neg_d;
    logic rneg_q, rneg_d;
    logic div_q, div_d;

    assign a_mag = (op[1] && op_a[31]) ? -op_a : op_a;
    assign b_mag = (op[1] && op_b[31]) ? -op_b : op_b;
`else
    logic op_unused;

    assign op_unused = op[1];
    assign a_mag     = op_a;
    assign b_mag     = op_b;
`endif

    // One multiply step: add multiplicand weighted by multiplier bit [count].
    assign mul_next = acc_q + (b_q[cnt_q[4:0]] ?
                      ({32'd0, a_q} << cnt_q[4:0]) : 64'd0);

    // One restoring-divide step; the dividend shifts out of a_q's MSB
    // while quotient bits shift into its LSB.
    assign rem_sh   = {rem_q, a_q[31]};
    assign trial    = rem_sh - {1'b0, b_q};
    assign q_bit    = ~trial[32];
    assign rem_next = q_bit ? trial[31:0] : rem_sh[31:0];
    assign quo_next = {a_q[30:0], q_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
`endif
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op[0] && (op_b == 32'd0)) begin
                            hi_d   = op_a;
                            lo_d   = 32'hFFFF_FFFF;
                            done_d = 1'b1;
                        end else begin
                            a_d     = a_mag;
                            b_d     = b_mag;
                            acc_d   = 64'd0;
                            rem_d   = 32'd0;
                            cnt_d   = 6'd0;
                            state_d = op[0] ? DIV_RUN : MUL_RUN;
`ifdef MULDIV_SIGNED_EN
                            sgn_d   = op[1];
                            neg_d   = op_a[31] ^ op_b[31];
                            rneg_d  = op_a[31];
                            div_d   = op[0];
`endif
                        end
                    end
                end
                MUL_RUN: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        cnt_d   = 6'd0;
                        state_d = IDLE;
                        hi_d    = mul_next[63:32];
                        lo_d    = mul_next[31:0];
                        done_d  = 1'b1;
`ifdef MULDIV_SIGNED_EN
                        // Signed results are published by FIX instead.
                        if (sgn_q) begin
                            state_d = FIX;
                            hi_d    = hi_q;
                            lo_d    = lo_q;
                            done_d  = 1'b0;
                        end
`endif
                    end
                end
                DIV_RUN: begin
                    rem_d = rem_next;
                    a_d   = quo_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        cnt_d   = 6'd0;
                        state_d = IDLE;
                        hi_d    = rem_next;
                        lo_d    = quo_next;
                        done_d  = 1'b1;
`ifdef MULDIV_SIGNED_EN
                        if (sgn_q) begin
                            state_d = FIX;
                            acc_d   = {rem_next, quo_next};
                            hi_d    = hi_q;
                            lo_d    = lo_q;
                            done_d  = 1'b0;
                        end
`endif
                    end
                end
`ifdef MULDIV_SIGNED_EN
                FIX: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (div_q) begin
                        lo_d = neg_q ? -acc_q[31:0] : acc_q[31:0];
                        hi_d = rneg_q ? -acc_q[63:32] : acc_q[63:32];
                    end else begin
                        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy && (start || rd_req);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        rd_req = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_req (rd_req),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain arithmetic on the operands.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic signed [63:0] sp;
        logic [63:0]        r;
        sa = a;
        sb = b;
        if (o[0]) begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else if (SIGNED && o[1]) begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr, sq};
            end else r = {a % b, a / b};
        end else begin
            if (SIGNED && o[1]) begin
                sp = 64'(sa) * 64'(sb);
                r  = sp;
            end else r = {32'd0, a} * {32'd0, b};
        end
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input string tag);
        int lat;
        int n;
        lat = (o[0] && b == 32'd0) ? 0 : ((SIGNED && o[1]) ? 33 : 32);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        rd_req = 1'b1;
        #1;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_res"}, {hi, lo}, exp);
        step();
        rd_req = 1'b0;
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nd;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        #1;
        rst_n = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        rd_req = 1'b1;
        repeat (5) begin
            check("rst_hilo", {hi, lo}, 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_stall", 64'(stall), 64'd0);
            step();
        end
        rd_req = 1'b0;

        run_op(2'b00, 32'd7, 32'd6, 64'd42, "mul7x6");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, "mulmax");
        run_op(2'b01, 32'd100, 32'd7, {32'd2, 32'd14}, "div100_7");
        run_op(2'b01, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "div0");
`ifdef MULDIV_SIGNED_EN
        run_op(2'b10, 32'hFFFF_FFFA, 32'd7,
               64'hFFFF_FFFF_FFFF_FFD6, "smul");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv");
`else
        run_op(2'b10, 32'hFFFF_FFFA, 32'd7,
               64'h0000_0006_FFFF_FFD6, "smul_u");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,
               {32'd1, 32'h7FFF_FFFC}, "sdiv_u");
`endif

        // Start and read while busy: stall until idle, then queued start.
        start = 1'b1;
        op    = 2'b00;
        op_a  = 32'd7;
        op_b  = 32'd6;
        step();
        start = 1'b0;
        repeat (9) step();
        start  = 1'b1;
        op_a   = 32'd3;
        op_b   = 32'd5;
        rd_req = 1'b1;
        #1;
        n = 0;
        while (busy && n < 100) begin
            check("hz_stall", 64'(stall), 64'd1);
            step();
            n++;
        end
        check("hz_lat", 64'(n), 64'd23);
        check("hz_done", 64'(done), 64'd1);
        check("hz_res1", {hi, lo}, 64'd42);
        check("hz_nostall", 64'(stall), 64'd0);
        step();
        start  = 1'b0;
        rd_req = 1'b0;
        check("hz_accept", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("hz_lat2", 64'(n), 64'd32);
        check("hz_res2", {hi, lo}, 64'd15);
        step();

        // Flush mid-operation keeps previous results and gives no done.
        run_op(2'b00, 32'd9, 32'd9, 64'd81, "pre");
        start = 1'b1;
        op    = 2'b00;
        op_a  = 32'h1234_5678;
        op_b  = 32'h0000_9ABC;
        step();
        start = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_done", 64'(done), 64'd0);
        nd = 0;
        repeat (40) begin
            step();
            if (done) nd++;
        end
        check("fl_nodone", 64'(nd), 64'd0);
        check("fl_keep", {hi, lo}, 64'd81);

        // Flush beats a simultaneous start.
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("fl_start", 64'(busy), 64'd0);

        // Reset mid-operation discards it.
        start = 1'b1;
        op    = 2'b01;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_hilo", {hi, lo}, 64'd0);
        step();

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (SIGNED && ro[1] && ra == 32'h8000_0000 &&
                rb == 32'hFFFF_FFFF)
                rb = 32'd1;
            run_op(ro, ra, rb, model(ro, ra, rb), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
